// File: rtl/input_sync_filter.sv
// input_sync_filter
// Multi-channel pin conditioner: per-channel synchroniser chain, consecutive-cycle
// debounce filter, registered filtered level and one-cycle rise/fall pulses.
// Every output comes straight from a flop; channels share no state.

module input_sync_filter #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CNT  = 16,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] dout,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  // A filter length of 1 still needs a one-bit counter so the compare is well formed.
  localparam int CW = (FILTER_CNT > 1) ? $clog2(FILTER_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  genvar i;
  generate
    for (i = 0; i < CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [CW-1:0]          cnt_q;
      logic                   dout_q;
      logic                   rise_q;
      logic                   fall_q;
      logic                   s;
      logic                   differs;
      logic                   update;

      // The last synchroniser stage is the only point where the pin is safe to use.
      assign s       = sync_q[SYNC_STAGES-1];
      assign differs = (s != dout_q);
      assign update  = differs && (cnt_q == CNT_MAX);

      // Plain shift chain; nothing may sit between stages or metastability can leak.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], din[i]};
        end
      end

      // Count consecutive cycles of disagreement; any agreeing cycle restarts the count.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (!differs || update) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end

      // Accept the new level and emit the matching edge pulse in the same edge.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout_q <= RST_VAL;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          rise_q <= update && s;
          fall_q <= update && !s;
          if (update) begin
            dout_q <= s;
          end
        end
      end

      assign dout[i] = dout_q;
      assign rise[i] = rise_q;
      assign fall[i] = fall_q;
    end
  endgenerate

endmodule

// File: tb/tb_input_sync_filter.sv
// Testbench for input_sync_filter (CH=4, SYNC_STAGES=2, FILTER_CNT=4, RST_VAL=0).
// A sliding-window model over the recorded pin/reset history is compared with the
// DUT every cycle; directed checks pin the expected latencies by hand.

module tb_input_sync_filter;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam bit RSTV = 1'b0;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] din;
  logic [CH-1:0] dout;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  int n_cmp = 0;
  int n_err = 0;

  input_sync_filter #(
    .CH(CH), .SYNC_STAGES(SYNC), .FILTER_CNT(FILT), .RST_VAL(RSTV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout), .rise(rise), .fall(fall)
  );

  // 50 MHz clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  // History of what the pins and reset looked like at every rising edge.
  logic [CH-1:0] din_h[$];
  bit            rst_h[$];
  logic [CH-1:0] m_dout = '0;
  logic [CH-1:0] m_rise = '0;
  logic [CH-1:0] m_fall = '0;
  bit            m_valid = 1'b0;

  // Synchronised level seen at edge k: the pin as sampled SYNC edges earlier,
  // or the reset level if a reset edge flushed the chain in between.
  function automatic bit s_at(int k, int ch);
    if (k - SYNC < 0) return RSTV;
    for (int m = k - SYNC; m < k; m++)
      if (rst_h[m]) return RSTV;
    return din_h[k-SYNC][ch];
  endfunction

  // A level is accepted at edge k when the synchronised level has disagreed with
  // the output on each of the last FILT edges with no reset among them.
  always @(posedge clk) begin
    int k;
    bit upd;
    din_h.push_back(din);
    rst_h.push_back(!rst_n);
    k = din_h.size() - 1;
    if (!rst_n) begin
      m_dout  = {CH{RSTV}};
      m_rise  = '0;
      m_fall  = '0;
      m_valid = 1'b1;
    end else begin
      for (int ch = 0; ch < CH; ch++) begin
        upd = 1'b1;
        for (int m = k - FILT + 1; m <= k; m++) begin
          if (m < 0) upd = 1'b0;
          else if (rst_h[m] || (s_at(m, ch) == m_dout[ch])) upd = 1'b0;
        end
        m_rise[ch] = upd && !m_dout[ch];
        m_fall[ch] = upd &&  m_dout[ch];
        if (upd) m_dout[ch] = !m_dout[ch];
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      n_cmp++;
      if (dout !== m_dout) begin
        n_err++;
        $display("[TB] FAIL model_dout @%0t: got %b expected %b", $time, dout, m_dout);
      end
      n_cmp++;
      if (rise !== m_rise) begin
        n_err++;
        $display("[TB] FAIL model_rise @%0t: got %b expected %b", $time, rise, m_rise);
      end
      n_cmp++;
      if (fall !== m_fall) begin
        n_err++;
        $display("[TB] FAIL model_fall @%0t: got %b expected %b", $time, fall, m_fall);
      end
      n_cmp++;
      if ((rise & fall) !== '0) begin
        n_err++;
        $display("[TB] FAIL rise_fall_excl @%0t: got %b expected 0000", $time, rise & fall);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic applyStimulus(input logic [CH-1:0] v);
    din = v;
  endtask

  task automatic checkOutput(input string name, input logic [CH-1:0] actual,
                             input logic [CH-1:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'hF);

    // Reset values held for three edges despite din all ones
    for (int r = 0; r < 3; r++) begin
      step(1);
      checkOutput("reset_dout", dout, 4'b0000);
      checkOutput("reset_rise", rise, 4'b0000);
      checkOutput("reset_fall", fall, 4'b0000);
    end

    // Clean rise/fall on channel 0
    rst_n = 1'b1;
    applyStimulus(4'b0000);
    step(8);
    applyStimulus(4'b0001);
    step(5);
    checkOutput("rise0_early_dout", dout, 4'b0000);
    step(1);
    checkOutput("rise0_dout", dout, 4'b0001);
    checkOutput("rise0_pulse", rise, 4'b0001);
    step(1);
    checkOutput("rise0_pulse_end", rise, 4'b0000);
    applyStimulus(4'b0000);
    step(5);
    checkOutput("fall0_early", fall, 4'b0000);
    step(1);
    checkOutput("fall0_pulse", fall, 4'b0001);
    checkOutput("fall0_dout", dout, 4'b0000);
    step(1);
    checkOutput("fall0_pulse_end", fall, 4'b0000);

    // Glitch of 3 cycles on channel 1 is absorbed
    applyStimulus(4'b0010);
    step(3);
    applyStimulus(4'b0000);
    step(10);
    checkOutput("glitch3_dout", dout, 4'b0000);

    // 4 cycles is just long enough
    applyStimulus(4'b0010);
    step(4);
    applyStimulus(4'b0000);
    step(2);
    checkOutput("pulse4_dout", dout, 4'b0010);
    checkOutput("pulse4_rise", rise, 4'b0010);
    step(10);
    checkOutput("pulse4_settled", dout, 4'b0000);

    // Chatter on channel 2, then hold high
    for (int t = 0; t < 20; t++) begin
      applyStimulus((t % 2 == 0) ? 4'b0100 : 4'b0000);
      step(2);
    end
    checkOutput("chatter_dout", dout, 4'b0000);
    applyStimulus(4'b0100);
    step(5);
    checkOutput("chatter_no_early", rise, 4'b0000);
    step(1);
    checkOutput("chatter_rise", rise, 4'b0100);
    checkOutput("chatter_dout_hi", dout, 4'b0100);
    applyStimulus(4'b0000);
    step(10);

    // Two channels switching together
    applyStimulus(4'b1010);
    step(6);
    checkOutput("simul_rise", rise, 4'b1010);
    checkOutput("simul_rise_fall", fall, 4'b0000);
    checkOutput("simul_dout", dout, 4'b1010);
    applyStimulus(4'b0000);
    step(6);
    checkOutput("simul_fall", fall, 4'b1010);
    checkOutput("simul_fall_rise", rise, 4'b0000);
    checkOutput("simul_dout_lo", dout, 4'b0000);
    step(4);

    // Reset with channel 3 part-way through its filter window (count at 2)
    applyStimulus(4'b1000);
    step(4);
    rst_n = 1'b0;
    step(1);
    checkOutput("midrst_dout", dout, 4'b0000);
    rst_n = 1'b1;
    step(5);
    checkOutput("midrst_early", dout, 4'b0000);
    step(1);
    checkOutput("midrst_dout_hi", dout, 4'b1000);
    checkOutput("midrst_rise", rise, 4'b1000);
    step(1);
    checkOutput("midrst_rise_end", rise, 4'b0000);

    // Reset landing on the edge that would have raised channel 0
    applyStimulus(4'b1001);
    step(5);
    rst_n = 1'b0;
    step(1);
    checkOutput("rstpulse_dout", dout, 4'b0000);
    checkOutput("rstpulse_rise", rise, 4'b0000);
    rst_n = 1'b1;
    step(8);
    checkOutput("rstpulse_recover", dout, 4'b1001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/input_sync_filter.md
# input_sync_filter

Multi-channel input conditioner for asynchronous external signals such as keys, switches and external strobes. Each channel has its own synchroniser chain, a consecutive-cycle debounce/glitch filter, a registered filtered level and one-cycle rise/fall pulses. It sits between the board pins and all internal logic in the `clk` domain, and replaces hand-built two-flop registers at every pin.

## Interface
Parameters:
- `CH`, default 4: number of independent channels, ≥1.
- `SYNC_STAGES`, default 2: synchroniser flops per channel, ≥2.
- `FILTER_CNT`, default 16: consecutive cycles a new synchronised level must persist before it is accepted, ≥1. A value of 1 means no filtering.
- `RST_VAL`, default 0: reset level of every synchroniser flop and of `dout`. The same value applies to all channels.

Ports:
- `clk`  input  1: system clock, 50 MHz. All state is updated on the rising edge.
- `rst_n`  input  1: reset. Synchronous, active-low, sampled on the rising edge of `clk`.
- `din`  input  CH: raw asynchronous inputs, one bit per channel.
- `dout`  output  CH: filtered, synchronised level per channel.
- `rise`  output  CH: one-cycle pulse when `dout[i]` changes 0→1.
- `fall`  output  CH: one-cycle pulse when `dout[i]` changes 1→0.

## Operation
- All channels are identical and fully independent. No state is shared between channels.
- **Synchroniser.** Per channel, a shift register `sync[i]` of `SYNC_STAGES` bits. `din[i]` enters stage 0, and the last stage is `s[i]`. No logic sits between stages.
- **Filter counter.** Per channel, a counter `cnt[i]` of width `$clog2(FILTER_CNT)` (minimum 1 bit). The rules below are evaluated every edge when `rst_n`=1:
  - If `s[i]` == `dout[i]`: `cnt[i]` <= 0 and `dout[i]` holds.
  - If `s[i]` != `dout[i]` and `cnt[i]` < `FILTER_CNT-1`: `cnt[i]` <= `cnt[i]`+1.
  - If `s[i]` != `dout[i]` and `cnt[i]` == `FILTER_CNT-1`: `dout[i]` <= `s[i]` and `cnt[i]` <= 0.
- Any single cycle where `s[i]` matches `dout[i]` discards all accumulated count. Glitches shorter than `FILTER_CNT` synchronised cycles never reach `dout`.
- `cnt` never exceeds `FILTER_CNT-1`, so there is no wrap-around.
- **Edge pulses.** They are registered and assert in the same edge that updates `dout[i]`:
  - `rise[i]` <= (update && `s[i]`==1).
  - `fall[i]` <= (update && `s[i]`==0).
  - Otherwise both are 0.
  - `rise[i]` and `fall[i]` are never high together. Each pulse lasts exactly one cycle.
- **Reset.** When `rst_n`=0 at an edge:
  - all `sync` stages <= `RST_VAL` and `dout` <= {CH{`RST_VAL`}};
  - `cnt` <= 0;
  - `rise` <= 0 and `fall` <= 0.
- **Reset mid-filter.** An accumulated count is discarded and any pending edge is lost.
- **After reset release.** A `din[i]` held at the opposite of `RST_VAL` is a genuine transition. It is reported through the normal path with a full-latency `dout` change and one `rise`/`fall` pulse.

## Timing
- Reset values: `dout` = {CH{`RST_VAL`}}, `rise` = 0, `fall` = 0. All are valid from the first edge with `rst_n` low.
- **Latency.** Take `din[i]` changing before edge 1 and then holding stable. Then:
  - `s[i]` changes after edge `SYNC_STAGES`;
  - `dout[i]` and the pulse change after edge `SYNC_STAGES+FILTER_CNT`.
  - With the defaults this is 18 edges. With `FILTER_CNT`=1 it is `SYNC_STAGES+1` edges.
- **Minimum accepted pulse width.** A level must persist at `s[i]` for `FILTER_CNT` consecutive cycles. A synchronised level lasting `FILTER_CNT-1` cycles produces no output change.
- **Back-to-back toggles.** Toggles at `din` faster than the filter window are fully absorbed. Two accepted transitions are at least `FILTER_CNT` cycles apart at `dout`.
- **Reset during a pulse.** If `rst_n` falls in the same edge that would update `dout`, reset wins: no pulse appears and `dout` = `RST_VAL`.
- All outputs come directly from flops. There is no combinational path from `din` to any output.

## Test plan
Settings for all scenarios: CH=4, SYNC_STAGES=2, FILTER_CNT=4, RST_VAL=0. Latency is therefore 6 edges.

- **Reset values.** Hold `rst_n`=0 for 3 edges with `din`=4'hF. Required: `dout`=0, `rise`=0, `fall`=0 throughout.
- **Clean rise/fall.** Release reset with `din`=0. Drive `din[0]`=1 before edge 1 and hold.
  - Required: `dout[0]`=1 after edge 6, and `rise[0]`=1 for exactly that one cycle.
  - Then drop `din[0]`: `fall[0]` pulses 6 edges later.
  - Other channels show no activity.
- **Glitch rejection.**
  - `din[1]` high for 3 cycles, then low: required `dout[1]` stays 0 and no pulses.
  - Repeating high-for-4 instead: required `dout[1]`=1 and one `rise[1]` pulse.
- **Chatter.** Toggle `din[2]` every 2 cycles for 40 cycles, then hold 1. Required: exactly one `rise[2]` pulse, 6 edges after the final hold begins.
- **Simultaneous channels.** Drive `din`=4'b1010 in one cycle. Required: `rise`=4'b1010 in a single cycle with `fall`=0. Then drive `din`=0: required `fall`=4'b1010 in a single cycle.
- **Reset mid-operation.** With `din[3]`=1 and `cnt[3]`=2, assert `rst_n`=0 for 1 edge and then release with `din[3]` held at 1. Required: `dout[3]`=0 during reset, then `dout[3]`=1 and one `rise[3]` pulse at 6 edges after release.
